// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low patterns ([6]=a .. [0]=g),
// receiver FSM states and the per-digit capture classes.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_0     = 7'b0000001;
  localparam seg7_t SEG_1     = 7'b1001111;
  localparam seg7_t SEG_2     = 7'b0010010;
  localparam seg7_t SEG_3     = 7'b0000110;
  localparam seg7_t SEG_4     = 7'b1001100;
  localparam seg7_t SEG_5     = 7'b0100100;
  localparam seg7_t SEG_6     = 7'b0100000;
  localparam seg7_t SEG_7     = 7'b0001111;
  localparam seg7_t SEG_8     = 7'b0000000;
  localparam seg7_t SEG_9     = 7'b0000100;
  localparam seg7_t SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    CAPTURED = 2'd2
  } state_e;

  // CLS_NONE marks a digit that has not been captured since reset.
  typedef enum logic [1:0] {
    CLS_NONE  = 2'd0,
    CLS_DEC   = 2'd1,
    CLS_BLANK = 2'd2,
    CLS_ERR   = 2'd3
  } digcls_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational inverse of the digit-to-segment encoder table.
module seg7_decode
  import seg7_pkg::*;
(
  input  seg7_t      seg_i,
  output logic [3:0] val_o,
  output logic       blank_o,
  output logic       err_o
);

  always_comb begin
    val_o   = 4'd0;
    blank_o = 1'b0;
    err_o   = 1'b0;
    unique case (seg_i)
      SEG_0:     val_o   = 4'd0;
      SEG_1:     val_o   = 4'd1;
      SEG_2:     val_o   = 4'd2;
      SEG_3:     val_o   = 4'd3;
      SEG_4:     val_o   = 4'd4;
      SEG_5:     val_o   = 4'd5;
      SEG_6:     val_o   = 4'd6;
      SEG_7:     val_o   = 4'd7;
      SEG_8:     val_o   = 4'd8;
      SEG_9:     val_o   = 4'd9;
      SEG_BLANK: blank_o = 1'b1;
      default:   err_o   = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_rx.sv
// Receive end of a multiplexed 7-segment scan bus: qualifies stable
// (digit, pattern) pairs, keeps a shadow of every digit and reports changes.
module seg7_scan_rx
  import seg7_pkg::*;
#(
  parameter  int NDIG       = 8,
  parameter  int STABLE_CYC = 4,
  localparam int DIGW       = $clog2(NDIG)
) (
  input  logic              clk,
  input  logic              rst,
  input  seg7_t             seg_i,
  input  logic [NDIG-1:0]   dig_sel_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DIGW-1:0]   out_idx,
  output logic [3:0]        out_val,
  output logic              out_blank,
  output logic              out_err,
  output logic [4*NDIG-1:0] digits_o,
  output logic [NDIG-1:0]   digits_vld_o,
  output logic              ovf_o
);

  localparam logic [7:0] STABLE_N = 8'(STABLE_CYC);

  seg7_t           segIn_q;
  logic [NDIG-1:0] selIn_q;

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [NDIG-1:0] latSel_q, latSel_d;
  seg7_t           latSeg_q, latSeg_d;

  logic            oneHot;
  logic            samePair;
  logic            restart;
  logic            capture;
  logic [DIGW-1:0] capIdx;
  logic [3:0]      decVal;
  logic            decBlank;
  logic            decErr;
  digcls_e         capCls;
  logic            newEvent;

  logic [NDIG-1:0][3:0] shVal_q;
  logic [NDIG-1:0]      shVld_q;
  digcls_e              shCls_q [NDIG];

  logic            outValid_q;
  logic [DIGW-1:0] outIdx_q;
  logic [3:0]      outVal_q;
  logic            outBlank_q;
  logic            outErr_q;
  logic            ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      segIn_q <= '0;
      selIn_q <= '0;
    end else begin
      segIn_q <= seg_i;
      selIn_q <= dig_sel_i;
    end
  end

  assign oneHot   = (selIn_q != '0) && ((selIn_q & (selIn_q - NDIG'(1))) == '0);
  assign samePair = (selIn_q == latSel_q) && (segIn_q == latSeg_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      latSel_q <= '0;
      latSeg_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      latSel_q <= latSel_d;
      latSeg_q <= latSeg_d;
    end
  end

  // Any new one-hot pair restarts qualification at a count of one; with a
  // single-cycle stability requirement that first sample already captures.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latSel_d = latSel_q;
    latSeg_d = latSeg_q;
    restart  = 1'b0;
    capture  = 1'b0;
    unique case (state_q)
      IDLE: restart = oneHot;
      SETTLE: begin
        if (!oneHot) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (samePair) begin
          cnt_d = cnt_q + 8'd1;
          if ((cnt_q + 8'd1) == STABLE_N) begin
            capture = 1'b1;
            state_d = CAPTURED;
          end
        end else begin
          restart = 1'b1;
        end
      end
      CAPTURED: begin
        if (!oneHot) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!samePair) begin
          restart = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (restart) begin
      latSel_d = selIn_q;
      latSeg_d = segIn_q;
      cnt_d    = 8'd1;
      if (STABLE_N == 8'd1) begin
        capture = 1'b1;
        state_d = CAPTURED;
      end else begin
        state_d = SETTLE;
      end
    end
  end

  seg7_decode u_decode (
    .seg_i   (segIn_q),
    .val_o   (decVal),
    .blank_o (decBlank),
    .err_o   (decErr)
  );

  always_comb begin
    capIdx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (selIn_q[i]) capIdx = DIGW'(i);
    end
  end

  // A blank only reports when the digit last held something else; an error
  // pattern reports on every capture so persistent faults stay visible.
  always_comb begin
    capCls   = CLS_DEC;
    newEvent = 1'b0;
    if (decErr) capCls = CLS_ERR;
    else if (decBlank) capCls = CLS_BLANK;
    if (capture) begin
      unique case (capCls)
        CLS_DEC:   newEvent = !shVld_q[capIdx] || (shVal_q[capIdx] != decVal);
        CLS_BLANK: newEvent = (shCls_q[capIdx] != CLS_BLANK);
        default:   newEvent = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shVal_q <= '0;
      shVld_q <= '0;
      for (int i = 0; i < NDIG; i++) shCls_q[i] <= CLS_NONE;
    end else if (capture) begin
      shCls_q[capIdx] <= capCls;
      shVal_q[capIdx] <= (capCls == CLS_DEC) ? decVal : 4'd0;
      shVld_q[capIdx] <= (capCls == CLS_DEC);
    end
  end

  // Single-entry slot: a pending event is never overwritten, so a new one
  // arriving while it waits is lost and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid_q <= 1'b0;
      outIdx_q   <= '0;
      outVal_q   <= '0;
      outBlank_q <= 1'b0;
      outErr_q   <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (newEvent) begin
      if (!outValid_q || out_ready) begin
        outValid_q <= 1'b1;
        outIdx_q   <= capIdx;
        outVal_q   <= decVal;
        outBlank_q <= decBlank;
        outErr_q   <= decErr;
      end else begin
        ovf_q <= 1'b1;
      end
    end else if (out_ready) begin
      outValid_q <= 1'b0;
    end
  end

  assign out_valid    = outValid_q;
  assign out_idx      = outIdx_q;
  assign out_val      = outVal_q;
  assign out_blank    = outBlank_q;
  assign out_err      = outErr_q;
  assign digits_o     = shVal_q;
  assign digits_vld_o = shVld_q;
  assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_seg7_scan_rx.sv
// Bench for seg7_scan_rx: directed vector table, hand-written reset/scan
// sequences and randomized traffic against a run-length reference model.
module tb_seg7_scan_rx;

  localparam int STABLE = 4;

  logic        clk;
  logic        rst;
  logic [6:0]  segBus;
  logic [7:0]  digSel;
  logic        outReady;
  logic        outValid;
  logic [2:0]  outIdx;
  logic [3:0]  outVal;
  logic        outBlank;
  logic        outErr;
  logic [31:0] digits;
  logic [7:0]  digitsVld;
  logic        ovf;

  seg7_scan_rx #(.NDIG(8), .STABLE_CYC(STABLE)) dut (
    .clk          (clk),
    .rst          (rst),
    .seg_i        (segBus),
    .dig_sel_i    (digSel),
    .out_valid    (outValid),
    .out_ready    (outReady),
    .out_idx      (outIdx),
    .out_val      (outVal),
    .out_blank    (outBlank),
    .out_err      (outErr),
    .digits_o     (digits),
    .digits_vld_o (digitsVld),
    .ovf_o        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] pats [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                            7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  int passCnt = 0;
  int checkCnt = 0;
  int hsTotal = 0;

  // Reference model: a pair captures when it has been seen for exactly STABLE
  // consecutive registered samples; the last reported state of each digit
  // decides whether the capture is worth an event.
  logic [7:0] mSampSel, mRunSel;
  logic [6:0] mSampSeg, mRunSeg;
  int         mRunLen;
  int         mShVal [8];
  bit         mShVld [8];
  int         mShCls [8];
  bit         mValid, mBlank, mErr, mOvf, mEv;
  logic [2:0] mIdx;
  logic [3:0] mVal;
  int         mPos, mK;

  function automatic int decodeModel(input logic [6:0] s);
    for (int k = 0; k < 10; k++) if (pats[k] == s) return k;
    if (s == 7'b1111111) return 10;
    return 11;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mSampSel = '0; mSampSeg = '0; mRunSel = '0; mRunSeg = '0; mRunLen = 0;
      for (int i = 0; i < 8; i++) begin mShVal[i] = 0; mShVld[i] = 0; mShCls[i] = 0; end
      mValid = 0; mIdx = '0; mVal = '0; mBlank = 0; mErr = 0; mOvf = 0;
    end else begin
      mEv = 0;
      if ($countones(mSampSel) != 1) mRunLen = 0;
      else if (mRunLen > 0 && mSampSel == mRunSel && mSampSeg == mRunSeg) begin
        if (mRunLen < 1000) mRunLen++;
      end else begin
        mRunSel = mSampSel; mRunSeg = mSampSeg; mRunLen = 1;
      end
      if (mRunLen == STABLE) begin
        mPos = 0;
        for (int i = 0; i < 8; i++) if (mSampSel[i]) mPos = i;
        mK = decodeModel(mSampSeg);
        if (mK < 10) begin
          mEv = !mShVld[mPos] || (mShVal[mPos] != mK);
          mShVal[mPos] = mK; mShVld[mPos] = 1; mShCls[mPos] = 1;
        end else if (mK == 10) begin
          mEv = (mShCls[mPos] != 2);
          mShVal[mPos] = 0; mShVld[mPos] = 0; mShCls[mPos] = 2;
        end else begin
          mEv = 1;
          mShVal[mPos] = 0; mShVld[mPos] = 0; mShCls[mPos] = 3;
        end
      end
      if (mEv) begin
        if (!mValid || outReady) begin
          mValid = 1; mIdx = 3'(mPos);
          mVal = (mK < 10) ? 4'(mK) : 4'd0;
          mBlank = (mK == 10); mErr = (mK == 11);
        end else begin
          mOvf = 1;
        end
      end else if (mValid && outReady) begin
        mValid = 0;
      end
      mSampSel = digSel; mSampSeg = segBus;
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic checkModel();
    logic [50:0] act, exp;
    logic [31:0] md;
    logic [7:0]  mv;
    for (int i = 0; i < 8; i++) begin md[4*i +: 4] = 4'(mShVal[i]); mv[i] = mShVld[i]; end
    act = {outValid, outValid ? {outIdx, outVal, outBlank, outErr} : 9'd0, digits, digitsVld, ovf};
    exp = {mValid, mValid ? {mIdx, mVal, mBlank, mErr} : 9'd0, md, mv, mOvf};
    check("model_cycle", 64'(act), 64'(exp));
    if (outValid && outReady) hsTotal++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    checkModel();
  endtask

  task automatic applyStimulus(input logic [7:0] sel, input logic [6:0] sg,
                               input logic rdy, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      digSel = sel; segBus = sg; outReady = rdy;
      tick();
    end
  endtask

  task automatic checkOutput(input string nm, input logic ev, input logic [2:0] ei,
                             input logic [3:0] evl, input logic eb, input logic ee,
                             input logic [7:0] evd, input logic [31:0] ed, input logic eo);
    check({nm, "_valid"}, 64'(outValid), 64'(ev));
    if (ev) check({nm, "_event"}, 64'({outIdx, outVal, outBlank, outErr}), 64'({ei, evl, eb, ee}));
    check({nm, "_vld"}, 64'(digitsVld), 64'(evd));
    check({nm, "_digits"}, 64'(digits), 64'(ed));
    check({nm, "_ovf"}, 64'(ovf), 64'(eo));
  endtask

  typedef struct {
    logic [7:0]  sel;
    logic [6:0]  seg;
    logic        rdy;
    int          hold;
    logic        expValid;
    logic [2:0]  expIdx;
    logic [3:0]  expVal;
    logic        expBlank;
    logic        expErr;
    logic [7:0]  expVld;
    logic [31:0] expDigits;
    logic        expOvf;
  } vec_t;

  vec_t vecs [14];
  logic [7:0] rs;
  logic [6:0] rg;
  int hsBefore;
  int r, q;

  initial begin
    vecs[0]  = '{8'h04, 7'b0010010, 1'b1, 4,  1'b1, 3'd2, 4'd2, 1'b0, 1'b0, 8'h04, 32'h00000200, 1'b0};
    vecs[1]  = '{8'h04, 7'b0000110, 1'b1, 3,  1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 8'h04, 32'h00000200, 1'b0};
    vecs[2]  = '{8'h08, 7'b0100100, 1'b1, 4,  1'b1, 3'd3, 4'd5, 1'b0, 1'b0, 8'h0C, 32'h00005200, 1'b0};
    vecs[3]  = '{8'h08, 7'b1111111, 1'b1, 4,  1'b1, 3'd3, 4'd0, 1'b1, 1'b0, 8'h04, 32'h00000200, 1'b0};
    vecs[4]  = '{8'h08, 7'b0110000, 1'b1, 4,  1'b1, 3'd3, 4'd0, 1'b0, 1'b1, 8'h04, 32'h00000200, 1'b0};
    vecs[5]  = '{8'h08, 7'b0110000, 1'b1, 4,  1'b1, 3'd3, 4'd0, 1'b0, 1'b1, 8'h04, 32'h00000200, 1'b0};
    vecs[6]  = '{8'h08, 7'b1111111, 1'b1, 4,  1'b1, 3'd3, 4'd0, 1'b1, 1'b0, 8'h04, 32'h00000200, 1'b0};
    vecs[7]  = '{8'h08, 7'b1111111, 1'b1, 4,  1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 8'h04, 32'h00000200, 1'b0};
    vecs[8]  = '{8'h04, 7'b0010010, 1'b1, 4,  1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 8'h04, 32'h00000200, 1'b0};
    vecs[9]  = '{8'h04, 7'b0001111, 1'b0, 10, 1'b1, 3'd2, 4'd7, 1'b0, 1'b0, 8'h04, 32'h00000700, 1'b0};
    vecs[10] = '{8'h03, 7'b1001111, 1'b1, 10, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 8'h04, 32'h00000700, 1'b0};
    vecs[11] = '{8'h01, 7'b0000001, 1'b0, 4,  1'b1, 3'd0, 4'd0, 1'b0, 1'b0, 8'h05, 32'h00000700, 1'b0};
    vecs[12] = '{8'h02, 7'b1001111, 1'b0, 4,  1'b1, 3'd0, 4'd0, 1'b0, 1'b0, 8'h07, 32'h00000710, 1'b1};
    vecs[13] = '{8'h00, 7'b1111111, 1'b1, 2,  1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 8'h07, 32'h00000710, 1'b1};

    rst = 1'b1; digSel = '0; segBus = 7'b1111111; outReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset", 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
    check("reset_fields", 64'({outIdx, outVal, outBlank, outErr}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].sel, vecs[i].seg, vecs[i].rdy, vecs[i].hold);
      applyStimulus(8'h00, 7'b1111111, vecs[i].rdy, 1);
      checkOutput($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expIdx, vecs[i].expVal,
                  vecs[i].expBlank, vecs[i].expErr, vecs[i].expVld, vecs[i].expDigits,
                  vecs[i].expOvf);
    end

    $display("[TB] reset during qualification");
    applyStimulus(8'h10, 7'b1001100, 1'b1, 2);
    @(negedge clk);
    rst = 1'b1;
    #2;
    checkOutput("rst_mid", 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) tick();
    checkOutput("requal_early", 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
    tick();
    checkOutput("requal_done", 1'b1, 3'd4, 4'd4, 1'b0, 1'b0, 8'h10, 32'h00040000, 1'b0);

    $display("[TB] full scan twice");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      hsBefore = hsTotal;
      for (int d = 0; d < 8; d++) applyStimulus(8'(1 << d), pats[d], 1'b1, 4);
      applyStimulus(8'h00, 7'b1111111, 1'b1, 3);
      check($sformatf("scan_pass%0d_events", pass + 1), 64'(hsTotal - hsBefore),
            (pass == 0) ? 64'd8 : 64'd0);
      check($sformatf("scan_pass%0d_digits", pass + 1), 64'({digits, digitsVld}),
            64'({32'h76543210, 8'hFF}));
    end

    $display("[TB] randomized traffic");
    rs = 8'h01;
    for (int n = 0; n < 250; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7) rs = 8'(1) << $urandom_range(0, 7);
      else if (r == 7) rs = 8'h00;
      else if (r == 8) rs = 8'($urandom);
      q = int'($urandom_range(0, 19));
      if (q < 12) rg = pats[q % 10];
      else if (q < 15) rg = 7'b1111111;
      else rg = 7'($urandom);
      applyStimulus(rs, rg, ($urandom_range(0, 3) != 0), int'($urandom_range(1, 6)));
    end

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
